pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Sits beside the IF/ID, ID/EX and EX/MEM registers.
//  Detects load-use hazards, EX-resolved taken branches and data-memory wait states.
//  Drives PC write-enable, IF/ID write/flush, ID/EX bubble/hold and EX/MEM hold.
//  A registered FSM plus counters handles multi-cycle stalls, flushes and a memory-wait timeout.
// PARAMETERS
//  REG_AW           5    register-index width
//  LOAD_STALL_CYCLES 1   bubbles inserted per load-use hazard (1..7)
//  FLUSH_CYCLES     1    cycles IF/ID+ID/EX held flushed after taken branch (1..7)
//  MEM_TIMEOUT      255  consecutive mem_busy cycles before mem_timeout sets (1..65535)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  id_valid       in   1       ID stage holds a real instruction
//  id_rs1         in   REG_AW  ID source register 1
//  id_rs2         in   REG_AW  ID source register 2
//  id_uses_rs2    in   1       ID instruction reads rs2 (R/S/B type)
//  ex_rd          in   REG_AW  EX destination register
//  ex_memread     in   1       EX instruction is a load
//  ex_branch_taken in  1       branch/jump resolved taken in EX this cycle
//  mem_busy       in   1       data memory not ready; MEM stage must hold
//  pc_write       out  1       PC update enable
//  ifid_write     out  1       IF/ID load enable
//  ifid_flush     out  1       IF/ID clear to NOP
//  idex_flush     out  1       ID/EX control fields zeroed (bubble)
//  idex_hold      out  1       ID/EX and EX/MEM keep current contents
//  mem_timeout    out  1       sticky error: mem_busy exceeded MEM_TIMEOUT
// BEHAVIOUR
//  State: RUN(0), STALL(1), FLUSH(2), MEMWAIT(3), 2-bit register. Counter cnt: 16-bit.
//  Outputs are Mealy: combinational from state and inputs. All events are sampled on the same cycle.
//  Defaults are pc_write=1, ifid_write=1, all flush/hold=0.
//  hazard = id_valid & ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
//  Priority each cycle: mem_busy > ex_branch_taken > hazard.
//  mem_busy (any state):
//   - pc_write=0, ifid_write=0, idex_hold=1; flush outputs 0.
//   - Next state is MEMWAIT; cnt increments, saturating at 16'hFFFF.
//   - When cnt reaches MEM_TIMEOUT, mem_timeout=1 until rst.
//   - A branch or hazard arriving during mem_busy is ignored, not queued; inputs are re-evaluated after release.
//  MEMWAIT & !mem_busy: cnt<=0, next RUN. This cycle is evaluated as RUN.
//  RUN & ex_branch_taken:
//   - ifid_flush=1, idex_flush=1; pc_write=1 so the target loads.
//   - FLUSH_CYCLES>1: next FLUSH with cnt<=FLUSH_CYCLES-1; otherwise stay RUN.
//  FLUSH: same outputs as a taken branch. cnt decrements; at cnt==1, next RUN. A new taken branch reloads cnt.
//  RUN & hazard:
//   - pc_write=0, ifid_write=0, idex_flush=1.
//   - LOAD_STALL_CYCLES>1: next STALL with cnt<=LOAD_STALL_CYCLES-1.
//  STALL: same outputs as a hazard. cnt decrements; at cnt==1, next RUN.
//   - A taken branch in STALL aborts the stall and is treated as RUN & ex_branch_taken.
//  Branch and hazard in the same cycle: the branch wins, because the flush squashes the hazarding ID instruction.
//  Reset (async, while rst=1):
//   - state=RUN, cnt=0, mem_timeout=0.
//   - Outputs forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, idex_hold=0.
//   - Reset mid-stall/flush/wait abandons the sequence. First cycle after deassert is plain RUN.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - Adds output ports stall_cnt, flush_cnt, memwait_cnt (each 32 bits, wrap-around).
//   - Each increments once per cycle with pc_write=0 & !mem_busy, ifid_flush=1, or idex_hold=1 respectively.
//   - All three reset to 0.
//  HAZARD_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. Load-use hazard:
//     - Stimulus: ex_memread=1, ex_rd=5, id_rs1=5, id_valid=1, LOAD_STALL_CYCLES=1.
//     - Response: one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle all defaults.
//  2. rd==x0 and unused rs2:
//     - Stimulus: ex_rd=0, id_rs1=0; separately ex_rd=7, id_rs2=7, id_uses_rs2=0.
//     - Response: no stall in either case.
//  3. Taken branch with FLUSH_CYCLES=2, plus simultaneous hazard:
//     - Stimulus: ex_branch_taken=1 for one cycle.
//     - Response: ifid_flush=idex_flush=1 for 2 cycles, pc_write=1 on the first.
//     - Stimulus: the same branch pulse with a hazard asserted in the same cycle.
//     - Response: flush only.
//  4. Memory wait and timeout:
//     - Stimulus: mem_busy=1 for 3 cycles during a pending hazard.
//     - Response: idex_hold=1, pc_write=0 for 3 cycles, then the hazard stall on the 4th cycle.
//     - Stimulus: with MEM_TIMEOUT=4, hold mem_busy=1 for 6 cycles.
//     - Response: mem_timeout rises after the 4th cycle and stays 1 until rst.
//  5. Reset mid-sequence:
//     - Stimulus: assert rst during STALL with LOAD_STALL_CYCLES=3.
//     - Response: outputs immediately take reset values; after release, state RUN, defaults, mem_timeout=0.
//  6. HAZARD_PERF_EN build:
//     - Stimulus: the scenarios above.
//     - Response: stall_cnt, flush_cnt and memwait_cnt equal the counted cycles exactly.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It detects load-use hazards, taken branches resolved in EX and data-memory
// wait states, and drives the PC / IF/ID / ID/EX / EX/MEM enables.
// Outputs are combinational from state and inputs. A 16-bit counter times
// multi-cycle stalls and flushes, and also counts memory-wait cycles.
// Optional build macro HAZARD_PERF_EN adds 32-bit wrap-around counters for
// stall, flush and memory-wait cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              idex_hold,
  output logic              mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       memwait_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  localparam logic [15:0] STALL_RELOAD = 16'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] FLUSH_RELOAD = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL  = 16'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        hazard;

  assign hazard = id_valid && ex_memread && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Output decode and next-state selection; priority mem_busy > branch > hazard.
  // A MEMWAIT state released by !mem_busy falls through to the RUN rules.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    idex_hold  = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nxt  = RUN;
      cnt_nxt    = '0;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_hold  = 1'b1;
      state_nxt  = MEMWAIT;
      // cnt still carries a stall/flush count on entry; restart the busy run
      if (state != MEMWAIT)
        cnt_nxt = 16'd1;
      else if (cnt != '1)
        cnt_nxt = cnt + 16'd1;
    end else if (ex_branch_taken || (state == FLUSH)) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (ex_branch_taken) begin
        if (FLUSH_CYCLES > 1) begin
          state_nxt = FLUSH;
          cnt_nxt   = FLUSH_RELOAD;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end else if (cnt <= 16'd1) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - 16'd1;
      end
    end else if (hazard || (state == STALL)) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      if (state == STALL) begin
        if (cnt <= 16'd1) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end else if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = STALL;
        cnt_nxt   = STALL_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end
  end

  // State, counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (mem_busy && (cnt_nxt >= TIMEOUT_VAL))
        mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  // Performance counters for stall, flush and memory-wait cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (!pc_write && !mem_busy) stall_cnt   <= stall_cnt + 32'd1;
      if (ifid_flush)             flush_cnt   <= flush_cnt + 32'd1;
      if (idex_hold)              memwait_cnt <= memwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl. Two instances with
// different stall/flush/timeout settings share one stimulus stream.
// A cycle-level reference model tracks remaining stall cycles, remaining
// flush cycles and the current busy-run length. Each cycle it pushes the
// expected outputs into a queue, and a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        idex_hold;
    logic        mem_timeout;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [31:0] mc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs2, ex_memread, ex_branch_taken, mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic [5:0]  o0, o1;
  logic [31:0] sc0, fc0, mc0, sc1, fc1, mc1;

  int LP [2] = '{1, 3};
  int FP [2] = '{1, 2};
  int TP [2] = '{6, 4};

  int          stall_left [2];
  int          flush_left [2];
  int          busy_run   [2];
  bit          tout       [2];
  int unsigned pc_s [2], pc_f [2], pc_m [2];

  exp_t q0 [$];
  exp_t q1 [$];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .MEM_TIMEOUT(6)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(o0[5]), .ifid_write(o0[4]), .ifid_flush(o0[3]), .idex_flush(o0[2]),
    .idex_hold(o0[1]), .mem_timeout(o0[0])
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc0), .flush_cnt(fc0), .memwait_cnt(mc0)
`endif
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(o1[5]), .ifid_write(o1[4]), .ifid_flush(o1[3]), .idex_flush(o1[2]),
    .idex_hold(o1[1]), .mem_timeout(o1[0])
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc1), .flush_cnt(fc1), .memwait_cnt(mc1)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign sc0 = '0; assign fc0 = '0; assign mc0 = '0;
  assign sc1 = '0; assign fc1 = '0; assign mc1 = '0;
`endif

  // Reference model: expected outputs for the current inputs, then advance.
  task automatic model_step(input int k, output exp_t e);
    bit hz;
    hz = id_valid && ex_memread && (ex_rd != 0) &&
         ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    e = '0;
    e.pc_write    = 1'b1;
    e.ifid_write  = 1'b1;
    e.mem_timeout = tout[k];
    e.sc = pc_s[k]; e.fc = pc_f[k]; e.mc = pc_m[k];
    if (rst) begin
      e.pc_write = 1'b0; e.ifid_write = 1'b0;
      e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      e.mem_timeout = 1'b0;
      e.sc = 0; e.fc = 0; e.mc = 0;
      stall_left[k] = 0; flush_left[k] = 0; busy_run[k] = 0; tout[k] = 0;
      pc_s[k] = 0; pc_f[k] = 0; pc_m[k] = 0;
    end else begin
      if (mem_busy) begin
        e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_hold = 1'b1;
        if (busy_run[k] < 65535) busy_run[k]++;
        if (busy_run[k] >= TP[k]) tout[k] = 1;
        stall_left[k] = 0; flush_left[k] = 0;
      end else begin
        busy_run[k] = 0;
        if (ex_branch_taken || flush_left[k] > 0) begin
          e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
          flush_left[k] = ex_branch_taken ? FP[k] - 1 : flush_left[k] - 1;
          stall_left[k] = 0;
        end else if (hz || stall_left[k] > 0) begin
          e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_flush = 1'b1;
          stall_left[k] = (stall_left[k] > 0) ? stall_left[k] - 1 : LP[k] - 1;
        end
      end
      if (!e.pc_write && !mem_busy) pc_s[k]++;
      if (e.ifid_flush) pc_f[k]++;
      if (e.idex_hold) pc_m[k]++;
    end
  endtask

  task automatic check(input int k, input exp_t e, input logic [5:0] o,
                       input logic [31:0] s, input logic [31:0] f, input logic [31:0] m);
    logic [5:0] ev;
    ev = {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.idex_hold, e.mem_timeout};
    vectors++;
    if (o !== ev) begin
      errors++;
      $display("FAIL outputs u%0d t=%0t got {pc,ifw,iff,idf,hold,tmo}=%b want %b", k, $time, o, ev);
    end
`ifdef HAZARD_PERF_EN
    vectors++;
    if (s !== e.sc || f !== e.fc || m !== e.mc) begin
      errors++;
      $display("FAIL perf u%0d t=%0t got %0d/%0d/%0d want %0d/%0d/%0d",
               k, $time, s, f, m, e.sc, e.fc, e.mc);
    end
`else
    if (s !== 32'd0 || f !== 32'd0 || m !== 32'd0) ;
`endif
  endtask

  // Monitor: compare DUT outputs mid-cycle against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); check(0, e, o0, sc0, fc0, mc0); end
      if (q1.size() > 0) begin e = q1.pop_front(); check(1, e, o1, sc1, fc1, mc1); end
    end
  end

  // Stimulus: random hazard/branch traffic, memory-busy bursts, random resets.
  initial begin
    exp_t e;
    int burst = 0;
    int rst_hold = 0;
    rst = 1'b1; id_valid = 0; id_uses_rs2 = 0; ex_memread = 0;
    ex_branch_taken = 0; mem_busy = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; flush_left[k] = 0; busy_run[k] = 0; tout[k] = 0;
      pc_s[k] = 0; pc_f[k] = 0; pc_m[k] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 3) rst = 1'b1;
      else if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end
      else if ($urandom_range(99) == 0) begin rst = 1'b1; rst_hold = $urandom_range(1); end
      else rst = 1'b0;
      id_valid        = ($urandom_range(7) != 0);
      id_uses_rs2     = $urandom_range(1);
      ex_memread      = ($urandom_range(2) != 0);
      ex_rd           = 5'($urandom_range(3));
      id_rs1          = 5'($urandom_range(3));
      id_rs2          = 5'($urandom_range(3));
      ex_branch_taken = ($urandom_range(6) == 0);
      if (burst > 0) begin
        mem_busy = 1'b1; burst--;
      end else if ($urandom_range(11) == 0) begin
        mem_busy = 1'b1; burst = $urandom_range(7);
      end else begin
        mem_busy = 1'b0;
      end
      model_step(0, e); q0.push_back(e);
      model_step(1, e); q1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d entries left want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
